// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and types for the single-cycle MIPS-I subset core.
//   - opcode / funct field values
//   - alu_op_t : operation selector driven by the decoder into mips_alu
//   - ctrl_t   : per-instruction control bundle produced by the decoder
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   typedef struct packed {
      logic reg_write;
      logic reg_dst;       // 1: write rd, 0: write rt
      logic alu_src;       // 1: ALU b = extended immediate
      logic mem_write;
      logic mem_to_reg;
      logic branch;        // beq
      logic branch_ne;     // bne
      logic jump;          // j / jal
      logic jal;
      logic jr;
      logic imm_zero_ext;  // logical immediates zero-extend
   } ctrl_t;

endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational ALU.
//   a, b   : operands (b is rt or the extended immediate)
//   shamt  : shift amount for sll/srl/sra (shifts operate on b)
//   op     : operation select
//   result : 32-bit result, zero : result == 0 (used for beq/bne)
module mips_alu
   import mips_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  alu_op_t     op,
   output logic [31:0] result,
   output logic        zero
);

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'b0, a < b};
         ALU_SLL:  result = b << shamt;
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = 32'($signed(b) >>> shamt);
         ALU_LUI:  result = {b[15:0], 16'h0};
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mips_single_cycle_mem.sv
// Word-addressed memories for the single-cycle core.
//   mips_imem : read-only program store, contents loaded from outside
//               (addr -> data, combinational)
//   mips_dmem : data store, combinational read, write on rising clk when we
module mips_imem #(
   parameter int WORDS = 256,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic [AW-1:0] addr,
   output logic [31:0]   data
);

   logic [31:0] imem [0:WORDS-1];

   assign data = imem[addr];

endmodule

module mips_dmem #(
   parameter int WORDS = 256,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] dmem [0:WORDS-1];

   always_ff @(posedge clk) begin
      if (we) dmem[addr] <= wdata;
   end

   assign rdata = dmem[addr];

endmodule

// File: rtl/mips_single_cycle.sv
// mips_single_cycle: 32-bit MIPS-I subset CPU, one instruction per clock.
//   clk   : rising-edge clock
//   reset : synchronous active-low; loads RESET_PC and clears all GPRs
// Instruction and data memories are internal (InstructionMemory, DataMemory).
module mips_single_cycle
   import mips_pkg::*;
#(
   parameter int          IMEM_WORDS = 256,
   parameter int          DMEM_WORDS = 256,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input logic clk,
   input logic reset
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0] pc;
   logic [31:0] gpr [0:31];
   logic [31:0] instr, pc_plus4, pc_next;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt, wr_addr;
   logic [15:0] imm;
   logic [25:0] target;
   logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_result, mem_rdata, wr_data;
   logic        alu_zero, branch_taken;
   ctrl_t       ctrl;
   alu_op_t     alu_op;

   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[25:0];

   mips_imem #(.WORDS(IMEM_WORDS)) InstructionMemory (
      .addr (pc[IAW+1:2]),
      .data (instr)
   );

   // Stores are suppressed while reset is asserted.
   mips_dmem #(.WORDS(DMEM_WORDS)) DataMemory (
      .clk   (clk),
      .we    (ctrl.mem_write & reset),
      .addr  (alu_result[DAW+1:2]),
      .wdata (rt_val),
      .rdata (mem_rdata)
   );

   always_comb begin
      ctrl   = '0;
      alu_op = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            case (funct)
               F_ADD, F_ADDU: alu_op = ALU_ADD;
               F_SUB, F_SUBU: alu_op = ALU_SUB;
               F_AND:         alu_op = ALU_AND;
               F_OR:          alu_op = ALU_OR;
               F_XOR:         alu_op = ALU_XOR;
               F_NOR:         alu_op = ALU_NOR;
               F_SLT:         alu_op = ALU_SLT;
               F_SLTU:        alu_op = ALU_SLTU;
               F_SLL:         alu_op = ALU_SLL;
               F_SRL:         alu_op = ALU_SRL;
               F_SRA:         alu_op = ALU_SRA;
               F_JR: begin
                  ctrl.reg_write = 1'b0;
                  ctrl.jr        = 1'b1;
               end
               default:       ctrl.reg_write = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_SLTI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            alu_op         = ALU_SLT;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ctrl.reg_write    = 1'b1;
            ctrl.alu_src      = 1'b1;
            ctrl.imm_zero_ext = 1'b1;
            alu_op = (opcode == OP_ANDI) ? ALU_AND :
                     (opcode == OP_ORI)  ? ALU_OR  :
                     (opcode == OP_XORI) ? ALU_XOR : ALU_LUI;
         end
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            alu_op      = ALU_SUB;
         end
         OP_BNE: begin
            ctrl.branch_ne = 1'b1;
            alu_op         = ALU_SUB;
         end
         OP_J: ctrl.jump = 1'b1;
         OP_JAL: begin
            ctrl.jump      = 1'b1;
            ctrl.jal       = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   // $0 is never written, so it reads 0 without a special case.
   assign rs_val  = gpr[rs];
   assign rt_val  = gpr[rt];
   assign imm_ext = ctrl.imm_zero_ext ? {16'h0, imm} : {{16{imm[15]}}, imm};
   assign alu_b   = ctrl.alu_src ? imm_ext : rt_val;

   mips_alu u_alu (
      .a      (rs_val),
      .b      (alu_b),
      .shamt  (shamt),
      .op     (alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   assign pc_plus4     = pc + 32'd4;
   assign branch_taken = (ctrl.branch & alu_zero) | (ctrl.branch_ne & ~alu_zero);
   assign pc_next = ctrl.jr     ? rs_val :
                    ctrl.jump   ? {pc_plus4[31:28], target, 2'b00} :
                    branch_taken ? pc_plus4 + {imm_ext[29:0], 2'b00} :
                    pc_plus4;

   assign wr_addr = ctrl.jal ? 5'd31 : (ctrl.reg_dst ? rd : rt);
   assign wr_data = ctrl.jal ? pc_plus4 : (ctrl.mem_to_reg ? mem_rdata : alu_result);

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++) gpr[i] <= '0;
      end else begin
         pc <= pc_next;
         if (ctrl.reg_write && wr_addr != 5'd0) gpr[wr_addr] <= wr_data;
      end
   end

   // Address bits that carry no information for word-indexed memories.
   logic unused_bits;
   assign unused_bits = &{1'b0, pc[1:0], alu_result[1:0], alu_result[31:DAW+2]};

endmodule

// File: tb/tb_mips_single_cycle.sv
module tb_mips_single_cycle;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mips_single_cycle dut (.clk(clk), .reset(reset));

   typedef struct {
      logic [31:0] instr;
      int          rd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [26];

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(int op, int addr);
      return {6'(op), 26'(addr >> 2)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_gprs_zero(input string name);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) acc = acc | dut.gpr[i];
      check(name, acc, 32'h0);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) dut.InstructionMemory.imem[i] = 32'h0;
   endtask

   task automatic enter_reset(input int edges);
      @(negedge clk);
      reset = 1'b0;
      step(edges);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{enc_i(8'h08, 0, 1, 5),        1,  32'h00000005}; // addi $1,$0,5
      tbl[1]  = '{enc_i(8'h08, 0, 2, -3),       2,  32'hFFFFFFFD}; // addi $2,$0,-3
      tbl[2]  = '{enc_r(1, 2, 3, 0, 8'h20),     3,  32'h00000002}; // add
      tbl[3]  = '{enc_r(2, 1, 4, 0, 8'h22),     4,  32'hFFFFFFF8}; // sub
      tbl[4]  = '{enc_r(2, 1, 5, 0, 8'h2A),     5,  32'h00000001}; // slt
      tbl[5]  = '{enc_r(2, 1, 6, 0, 8'h2B),     6,  32'h00000000}; // sltu
      tbl[6]  = '{enc_i(8'h0F, 0, 7, 16'h1234), 7,  32'h12340000}; // lui
      tbl[7]  = '{enc_i(8'h0D, 7, 7, 16'h5678), 7,  32'h12345678}; // ori
      tbl[8]  = '{enc_i(8'h08, 0, 0, 7),        0,  32'h00000000}; // addi $0
      tbl[9]  = '{enc_r(7, 2, 8, 0, 8'h26),     8,  32'hEDCBA985}; // xor
      tbl[10] = '{enc_r(1, 0, 9, 0, 8'h27),     9,  32'hFFFFFFFA}; // nor
      tbl[11] = '{enc_r(0, 1, 10, 4, 8'h00),    10, 32'h00000050}; // sll
      tbl[12] = '{enc_r(0, 2, 11, 28, 8'h02),   11, 32'h0000000F}; // srl
      tbl[13] = '{enc_r(0, 2, 12, 1, 8'h03),    12, 32'hFFFFFFFE}; // sra
      tbl[14] = '{enc_i(8'h0A, 2, 13, -2),      13, 32'h00000001}; // slti
      tbl[15] = '{enc_i(8'h0C, 2, 14, 16'hFF00),14, 32'h0000FF00}; // andi zero-ext
      tbl[16] = '{enc_i(8'h0E, 1, 15, 16'hFFFF),15, 32'h0000FFFA}; // xori zero-ext
      tbl[17] = '{enc_i(8'h09, 7, 16, -16'sh5678),16, 32'h12340000}; // addiu
      tbl[18] = '{enc_r(0, 1, 17, 0, 8'h23),    17, 32'hFFFFFFFB}; // subu
      tbl[19] = '{enc_r(2, 10, 18, 0, 8'h24),   18, 32'h00000050}; // and
      tbl[20] = '{enc_r(1, 10, 19, 0, 8'h25),   19, 32'h00000055}; // or
      tbl[21] = '{enc_r(1, 2, 20, 0, 8'h2A),    20, 32'h00000000}; // slt false
      tbl[22] = '{enc_r(1, 2, 21, 0, 8'h2B),    21, 32'h00000001}; // sltu true
      tbl[23] = '{enc_i(8'h3F, 1, 22, 7),       22, 32'h00000000}; // bad opcode
      tbl[24] = '{enc_r(1, 1, 23, 0, 8'h3F),    23, 32'h00000000}; // bad funct
      tbl[25] = '{enc_i(8'h08, 2, 24, 3),       24, 32'h00000000}; // addi wrap

      // ---- reset and ALU table ----
      clear_imem();
      for (int i = 0; i < 26; i++) dut.InstructionMemory.imem[i] = tbl[i].instr;
      step(3);
      check("reset pc", dut.pc, 32'h0);
      check_gprs_zero("reset gprs");
      release_reset();
      for (int i = 0; i < 26; i++) begin
         step(1);
         check($sformatf("alu%0d reg", i), dut.gpr[tbl[i].rd], tbl[i].exp);
         check($sformatf("alu%0d pc", i), dut.pc, 32'(4 * (i + 1)));
      end

      // ---- memory ----
      enter_reset(1);
      clear_imem();
      dut.DataMemory.dmem[1]  = 32'h0;
      dut.DataMemory.dmem[14] = 32'hCAFE0000;
      dut.DataMemory.dmem[15] = 32'h0;
      dut.InstructionMemory.imem[0] = enc_i(8'h08, 0, 1, 8'h3C);
      dut.InstructionMemory.imem[1] = enc_i(8'h08, 0, 2, 81);
      dut.InstructionMemory.imem[2] = enc_i(8'h2B, 1, 2, 0);      // sw $2,0($1)
      dut.InstructionMemory.imem[3] = enc_i(8'h23, 1, 3, 0);      // lw $3,0($1)
      dut.InstructionMemory.imem[4] = enc_i(8'h2B, 0, 1, 16'h405);// wraps to word 1
      dut.InstructionMemory.imem[5] = enc_i(8'h23, 1, 4, -4);     // word 14
      dut.InstructionMemory.imem[6] = enc_i(8'h23, 0, 5, 16'h43E);// wraps to word 15
      release_reset();
      step(3);
      check("sw dmem15", dut.DataMemory.dmem[15], 32'h51);
      step(1);
      check("lw r3", dut.gpr[3], 32'h51);
      step(3);
      check("sw wrap dmem1", dut.DataMemory.dmem[1], 32'h3C);
      check("lw neg off", dut.gpr[4], 32'hCAFE0000);
      check("lw wrap", dut.gpr[5], 32'h51);

      // ---- control flow ----
      enter_reset(1);
      clear_imem();
      dut.InstructionMemory.imem[0]  = enc_i(8'h08, 0, 1, 1);
      dut.InstructionMemory.imem[4]  = enc_i(8'h04, 0, 0, 2);     // 0x10 beq -> 0x1C
      dut.InstructionMemory.imem[7]  = enc_i(8'h05, 0, 0, 5);     // 0x1C bne not taken
      dut.InstructionMemory.imem[8]  = enc_j(8'h03, 32'h40);      // 0x20 jal 0x40
      dut.InstructionMemory.imem[9]  = enc_j(8'h02, 32'h40);      // 0x24 j 0x40
      dut.InstructionMemory.imem[16] = enc_i(8'h05, 1, 0, 3);     // 0x40 bne taken -> 0x50
      dut.InstructionMemory.imem[20] = enc_r(31, 0, 0, 0, 8'h08); // 0x50 jr $31
      release_reset();
      step(4);
      check("pc before beq", dut.pc, 32'h10);
      step(1);
      check("beq taken", dut.pc, 32'h1C);
      step(1);
      check("bne equal", dut.pc, 32'h20);
      step(1);
      check("jal pc", dut.pc, 32'h40);
      check("jal r31", dut.gpr[31], 32'h24);
      step(1);
      check("bne taken", dut.pc, 32'h50);
      step(1);
      check("jr", dut.pc, 32'h24);
      step(1);
      check("j", dut.pc, 32'h40);

      // ---- power program: 3^4 ----
      enter_reset(1);
      clear_imem();
      dut.DataMemory.dmem[15] = 32'h0;
      dut.InstructionMemory.imem[0]  = enc_i(8'h08, 0, 1, 3);     // base
      dut.InstructionMemory.imem[1]  = enc_i(8'h08, 0, 2, 4);     // exponent
      dut.InstructionMemory.imem[2]  = enc_i(8'h08, 0, 3, 1);     // result
      dut.InstructionMemory.imem[3]  = enc_i(8'h08, 0, 4, 0);     // 0x0C outer: acc=0
      dut.InstructionMemory.imem[4]  = enc_r(1, 0, 5, 0, 8'h20);  // cnt=base
      dut.InstructionMemory.imem[5]  = enc_r(4, 3, 4, 0, 8'h20);  // 0x14 inner: acc+=result
      dut.InstructionMemory.imem[6]  = enc_i(8'h08, 5, 5, -1);
      dut.InstructionMemory.imem[7]  = enc_i(8'h05, 5, 0, -3);    // bne -> 0x14
      dut.InstructionMemory.imem[8]  = enc_r(4, 0, 3, 0, 8'h20);  // result=acc
      dut.InstructionMemory.imem[9]  = enc_i(8'h08, 2, 2, -1);
      dut.InstructionMemory.imem[10] = enc_i(8'h05, 2, 0, -8);    // bne -> 0x0C
      dut.InstructionMemory.imem[20] = enc_i(8'h2B, 0, 3, 8'h3C); // 0x50 sw
      release_reset();
      begin
         int cyc;
         cyc = 0;
         while (dut.pc !== 32'h54 && cyc < 2000) begin
            step(1);
            cyc++;
         end
         check("power reached 0x54", 32'(cyc < 2000), 32'h1);
      end
      check("power dmem15", dut.DataMemory.dmem[15], 32'h51);
      check("power r3", dut.gpr[3], 32'h51);

      // ---- mid-run reset ----
      enter_reset(1);
      release_reset();
      step(20);
      enter_reset(1);
      check("midrun pc", dut.pc, 32'h0);
      check_gprs_zero("midrun gprs");
      check("midrun dmem15 kept", dut.DataMemory.dmem[15], 32'h51);
      check("midrun dmem1 kept", dut.DataMemory.dmem[1], 32'h3C);

      // store at pc 0 must be held off while reset is asserted
      dut.InstructionMemory.imem[0] = enc_i(8'h2B, 0, 0, 8'h3C);  // sw $0,0x3C($0)
      step(2);
      check("no store in reset", dut.DataMemory.dmem[15], 32'h51);
      release_reset();
      step(1);
      check("store after reset", dut.DataMemory.dmem[15], 32'h0);
      check("pc after reset", dut.pc, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
